// File: rtl/fetch_pc_unit_if.sv
// ============================================================================
//  Module      : fetch_pc_unit_if
//  Description : Signal bundle between the instruction-fetch stage and its
//                environment (hazard unit, ID stage, instruction memory and
//                the IF/ID consumer).
//                  Control in  : stall, br_taken, br_target, annul
//                  Memory      : imem_addr (out), imem_instr (in)
//                  IF/ID out   : if_id_instr, if_id_pc, if_id_npc, if_id_valid
//                  Status out  : pc_oor, align_err, fetch_count
//                Modport "slave" is the fetch unit; "master" is everything
//                around it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_pc_unit_if;
    // Control from hazard unit / ID stage
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        annul;

    // Instruction memory (combinational read)
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;

    // IF/ID pipeline register
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_npc;
    logic        if_id_valid;

    // Status
    logic        pc_oor;
    logic        align_err;
    logic [31:0] fetch_count;

    // Fetch unit side
    modport slave (
        input  stall,
        input  br_taken,
        input  br_target,
        input  annul,
        input  imem_instr,
        output imem_addr,
        output if_id_instr,
        output if_id_pc,
        output if_id_npc,
        output if_id_valid,
        output pc_oor,
        output align_err,
        output fetch_count
    );

    // Environment side
    modport master (
        output stall,
        output br_taken,
        output br_target,
        output annul,
        output imem_instr,
        input  imem_addr,
        input  if_id_instr,
        input  if_id_pc,
        input  if_id_npc,
        input  if_id_valid,
        input  pc_oor,
        input  align_err,
        input  fetch_count
    );
endinterface : fetch_pc_unit_if

`default_nettype wire

// File: rtl/fetch_pc_unit.sv
// ============================================================================
//  Module      : fetch_pc_unit
//  Description : SPARC instruction-fetch stage. Holds the PC/nPC pair, drives
//                the instruction-memory address straight from PC, captures
//                the returned word into the IF/ID register and handles stall,
//                delayed-branch redirect and delay-slot annulment.
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low reset
//                bus    - fetch_pc_unit_if.slave (control, memory, IF/ID,
//                         status; see interface header)
//  Parameters  : RESET_PC   - PC after reset (word aligned)
//                IMEM_DEPTH - instruction memory depth in words
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 128
) (
    input  logic           clk,
    input  logic           rst_n,
    fetch_pc_unit_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Low address bits are dropped so a badly set parameter can never put a
    // misaligned address on the memory bus.
    localparam logic [31:0] c_RESET_PC    = {RESET_PC[31:2], 2'b00};
    localparam logic [31:0] c_RESET_NPC   = c_RESET_PC + 32'd4;
    localparam logic [31:0] c_OOR_LIMIT   = 32'(4 * IMEM_DEPTH);
    localparam logic [31:0] c_SPARC_NOP   = 32'h0100_0000;
    localparam logic [31:0] c_WORD_STRIDE = 32'd4;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [31:0] r_pc;
    logic [31:0] r_npc;
    logic [31:0] r_if_id_instr;
    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_npc;
    logic        r_if_id_valid;
    logic        r_pc_oor;
    logic        r_align_err;
    logic [31:0] r_fetch_count;

    // ------------------------------------------------------------------------
    // Next-state datapath
    // ------------------------------------------------------------------------
    logic [31:0] w_target_aligned;
    logic [31:0] w_pc_next;
    logic [31:0] w_npc_next;
    logic [31:0] w_latch_instr;
    logic        w_latch_valid;
    logic        w_target_misaligned;
    logic        w_oor_hit;

    always_comb begin
        w_target_aligned    = {bus.br_target[31:2], 2'b00};
        w_target_misaligned = bus.br_target[1:0] != 2'b00;

        // Delayed branch: the slot instruction is already in IF, so a taken
        // branch only changes where fetch goes *after* it. The new PC is
        // therefore either the old nPC or the target, and in both cases that
        // value is also the nPC recorded for the instruction being latched.
        w_pc_next  = bus.br_taken ? w_target_aligned : r_npc;
        w_npc_next = w_pc_next + c_WORD_STRIDE;

        // An annulled slot is replaced by a nop so that downstream stages see
        // a harmless instruction even if they ignore the valid bit.
        w_latch_instr = bus.annul ? c_SPARC_NOP : bus.imem_instr;
        w_latch_valid = ~bus.annul;

        w_oor_hit = w_pc_next >= c_OOR_LIMIT;
    end

    // ------------------------------------------------------------------------
    // PC / nPC and IF/ID register. Stall freezes everything, including the
    // branch and annul inputs, which ID keeps asserting until it is released.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= c_RESET_PC;
            r_npc         <= c_RESET_NPC;
            r_if_id_instr <= '0;
            r_if_id_pc    <= '0;
            r_if_id_npc   <= '0;
            r_if_id_valid <= 1'b0;
        end else if (!bus.stall) begin
            r_pc          <= w_pc_next;
            r_npc         <= w_npc_next;
            r_if_id_instr <= w_latch_instr;
            r_if_id_pc    <= r_pc;
            r_if_id_npc   <= w_pc_next;
            r_if_id_valid <= w_latch_valid;
        end
    end

    // ------------------------------------------------------------------------
    // Status: sticky error flags and count of live instructions handed to ID.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_oor      <= 1'b0;
            r_align_err   <= 1'b0;
            r_fetch_count <= '0;
        end else if (!bus.stall) begin
            if (w_oor_hit) begin
                r_pc_oor <= 1'b1;
            end
            if (bus.br_taken && w_target_misaligned) begin
                r_align_err <= 1'b1;
            end
            if (w_latch_valid) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. The memory address is PC itself with no register stage, so the
    // instruction for PC is available in the same cycle.
    // ------------------------------------------------------------------------
    assign bus.imem_addr   = r_pc;
    assign bus.if_id_instr = r_if_id_instr;
    assign bus.if_id_pc    = r_if_id_pc;
    assign bus.if_id_npc   = r_if_id_npc;
    assign bus.if_id_valid = r_if_id_valid;
    assign bus.pc_oor      = r_pc_oor;
    assign bus.align_err   = r_align_err;
    assign bus.fetch_count = r_fetch_count;

endmodule : fetch_pc_unit

`default_nettype wire

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- SPARC instruction-fetch stage; sits directly upstream of the instruction memory.
- Holds the PC/nPC pair and drives the instruction-memory word address combinationally from PC.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles pipeline stall, taken-branch redirect from ID (delayed-branch semantics: the delay slot is already in IF) and delay-slot annulment.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset; bits [1:0] must be 0.
- IMEM_DEPTH, 128, instruction-memory depth in words; used for the out-of-range flag.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hazard-unit hold; freezes PC, nPC and IF/ID.
- br_taken  input  1  taken control transfer resolved in ID this cycle.
- br_target  input  32  byte address of the branch target.
- annul  input  1  squash the instruction currently in IF (the delay slot).
- imem_instr  input  32  instruction word returned by instruction memory for imem_addr (combinational, same cycle).
- imem_addr  output  32  byte address to instruction memory; equals PC.
- if_id_instr  output  32  latched instruction.
- if_id_pc  output  32  PC of the latched instruction.
- if_id_npc  output  32  nPC at the time of latch (PC+4 or target).
- if_id_valid  output  1  latched instruction is live (not a bubble or annulled).
- pc_oor  output  1  sticky: PC reached or passed 4*IMEM_DEPTH.
- align_err  output  1  sticky: a br_target with [1:0]≠0 was accepted.
- fetch_count  output  32  number of valid instructions latched into IF/ID.

Behaviour:
- Reset (rst_n low, asynchronous, any cycle including mid-redirect):
  - PC=RESET_PC, nPC=RESET_PC+4.
  - if_id_instr=0, if_id_pc=0, if_id_npc=0, if_id_valid=0.
  - pc_oor=0, align_err=0, fetch_count=0.
- First rising edge after deassertion performs a normal fetch of RESET_PC.
- imem_addr = PC at all times; there is no registered delay. Instruction memory indexes words by addr[31:2].
- Priority per edge: stall > br_taken > sequential.
- stall=1:
  - All state holds, including PC, nPC, IF/ID, counters and flags.
  - br_taken and annul are ignored; ID holds its instruction and reasserts them.
- stall=0, br_taken=0 (sequential):
  - PC←nPC, nPC←nPC+4.
  - IF/ID←{imem_instr, PC, nPC}, if_id_valid←~annul.
- stall=0, br_taken=1 (redirect):
  - PC←{br_target[31:2],2'b00}, nPC←that value+4.
  - IF/ID captures the current IF instruction as the delay slot: if_id_valid←~annul, if_id_npc←aligned target.
  - If br_target[1:0]≠0, set align_err.
- annul=1 (with stall=0):
  - if_id_instr←32'h0100_0000 (SPARC nop), if_id_valid←0.
  - if_id_pc and if_id_npc are latched normally.
  - The PC update is unaffected by annul.
- fetch_count increments by 1 on every non-stalled edge where if_id_valid is written 1. It wraps modulo 2^32.
- pc_oor sets when the next PC value ≥ 4*IMEM_DEPTH. Fetch continues; memory returns whatever it maps.
- Arithmetic: all adds are 32-bit modulo; PC 32'hFFFF_FFFC + 4 wraps to 0.
- Sticky flags clear only on reset.
- Simultaneous stall and reset: reset wins.

Test Plan:
- Reset/sequential: hold rst_n=0 for 3 cycles, then release, stall=0, RESET_PC=0.
  - While in reset: imem_addr=0, if_id_valid=0.
  - After edge 1: if_id_pc=0, valid=1, imem_addr=4.
  - After edge 4: imem_addr=16, fetch_count=4.
- Stall: with PC=8, assert stall for 3 cycles.
  - imem_addr stays 8; IF/ID, fetch_count and if_id_valid are unchanged.
  - On release, the next edge latches pc=8.
- Delayed branch: ID branch at 0x10 with delay slot at 0x14 in IF; br_taken=1, br_target=0x40.
  - if_id_pc=0x14, valid=1, if_id_npc=0x40.
  - Next imem_addr=0x40, then 0x44.
- Annulled delay slot: same as the branch case plus annul=1.
  - if_id_instr=32'h0100_0000, valid=0, fetch_count unchanged, imem_addr=0x40.
- Branch under stall: stall=1 and br_taken=1 with target 0x80 for 2 cycles, then stall=0 with br_taken still 1.
  - No redirect during the stall.
  - Redirect to 0x80 on the release edge only.
- Boundaries:
  - br_target=0x4A: PC=0x48, align_err=1.
  - Sequential fetch past 0x1FC with IMEM_DEPTH=128: pc_oor=1 at PC=0x200, and it stays set.
  - Async reset mid-sequence: outputs clear immediately, without waiting for a clock edge.
